// File: rtl/dmem_responder.sv
// Word-addressed data memory answering tagged load/store requests through a
// fixed-latency pipeline and a credit-limited response FIFO. Define DMEM_ALIGN_CHK_EN to flag misaligned accesses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int QDEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [5:0]  req_tag,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [5:0]  rsp_tag,
    output logic        rsp_err,
    input  logic        rsp_grant
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int EW = 39;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_rdData;

    logic          w_accept;
    logic          w_pop;
    logic          w_mis;
    logic [AW-1:0] w_idx;
    logic          w_unused;

    assign w_accept = req_valid && req_ready;
    assign w_idx    = req_addr[AW+1:2];
    assign w_unused = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHK_EN
    assign w_mis = (req_addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    // Memory has no reset; a load samples the array on its accept edge.
    always_ff @(posedge clk) begin
        if (w_accept && !w_mis) begin
            if (req_we) begin
                r_mem[w_idx] <= req_wdata;
            end else begin
                r_rdData <= r_mem[w_idx];
            end
        end
    end

    logic          r_s0Valid;
    logic          r_s0We;
    logic          r_s0Err;
    logic [5:0]    r_s0Tag;
    logic [31:0]   r_s0Wdata;
    logic [31:0]   w_s0Data;
    logic [EW-1:0] w_s0Entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0Valid <= 1'b0;
            r_s0We    <= 1'b0;
            r_s0Err   <= 1'b0;
            r_s0Tag   <= '0;
            r_s0Wdata <= '0;
        end else begin
            r_s0Valid <= w_accept;
            if (w_accept) begin
                r_s0We    <= req_we;
                r_s0Err   <= w_mis;
                r_s0Tag   <= req_tag;
                r_s0Wdata <= req_wdata;
            end
        end
    end

    assign w_s0Data  = r_s0Err ? 32'h0 : (r_s0We ? r_s0Wdata : r_rdData);
    assign w_s0Entry = {r_s0Err, r_s0Tag, w_s0Data};

    logic          w_pushValid;
    logic [EW-1:0] w_pushEntry;

    // Extra delay stages so the FIFO sees the entry LATENCY edges after accept.
    generate
        if (LATENCY > 1) begin : g_ext
            localparam int XS = LATENCY - 1;
            logic [XS-1:0] r_xValid;
            logic [EW-1:0] r_xEntry [XS];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_xValid <= '0;
                    for (int i = 0; i < XS; i++) begin
                        r_xEntry[i] <= '0;
                    end
                end else begin
                    r_xValid[0] <= r_s0Valid;
                    r_xEntry[0] <= w_s0Entry;
                    for (int i = 1; i < XS; i++) begin
                        r_xValid[i] <= r_xValid[i-1];
                        r_xEntry[i] <= r_xEntry[i-1];
                    end
                end
            end

            assign w_pushValid = r_xValid[XS-1];
            assign w_pushEntry = r_xEntry[XS-1];
        end else begin : g_direct
            assign w_pushValid = r_s0Valid;
            assign w_pushEntry = w_s0Entry;
        end
    endgenerate

    logic [EW-1:0] r_fifo [QDEPTH];
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_credit;
    logic          r_headValid;
    logic [EW-1:0] r_headEntry;

    logic          w_headFree;
    logic          w_fifoPop;
    logic          w_bypass;
    logic          w_fifoPush;

    assign w_pop      = r_headValid && rsp_grant;
    assign w_headFree = !r_headValid || rsp_grant;
    assign w_fifoPop  = w_headFree && (r_count != '0);
    assign w_bypass   = w_headFree && (r_count == '0) && w_pushValid;
    assign w_fifoPush = w_pushValid && !w_bypass;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_fifoPush) begin
            r_fifo[r_wrPtr] <= w_pushEntry;
        end
    end

    // The head register is refilled from the backing FIFO, or straight from the pipeline when the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_headValid <= 1'b0;
            r_headEntry <= '0;
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
            r_count     <= '0;
            r_credit    <= '0;
        end else begin
            if (w_headFree) begin
                if (r_count != '0) begin
                    r_headValid <= 1'b1;
                    r_headEntry <= r_fifo[r_rdPtr];
                end else if (w_pushValid) begin
                    r_headValid <= 1'b1;
                    r_headEntry <= w_pushEntry;
                end else begin
                    r_headValid <= 1'b0;
                end
            end
            if (w_fifoPop) begin
                r_rdPtr <= ptrInc(r_rdPtr);
            end
            if (w_fifoPush) begin
                r_wrPtr <= ptrInc(r_wrPtr);
            end
            if (w_fifoPush && !w_fifoPop) begin
                r_count <= r_count + CW'(1);
            end else if (w_fifoPop && !w_fifoPush) begin
                r_count <= r_count - CW'(1);
            end
            if (w_accept && !w_pop) begin
                r_credit <= r_credit + CW'(1);
            end else if (w_pop && !w_accept) begin
                r_credit <= r_credit - CW'(1);
            end
        end
    end

    assign req_ready = (r_credit < CW'(QDEPTH));
    assign rsp_valid = r_headValid;
    assign rsp_err   = r_headEntry[38];
    assign rsp_tag   = r_headEntry[37:32];
    assign rsp_data  = r_headEntry[31:0];

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder: a word-array reference model
// predicts each response on accept; a negedge monitor checks data, order, latency and credit.
module tb_dmem_responder;

    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 2;
    localparam int QDEPTH      = 4;
    localparam int AW          = $clog2(DEPTH_WORDS);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [5:0]  req_tag = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [5:0]  rsp_tag;
    logic        rsp_err;
    logic        rsp_grant = 1'b0;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .LATENCY    (LATENCY),
        .QDEPTH     (QDEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_tag  (req_tag),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_tag  (rsp_tag),
        .rsp_err  (rsp_err),
        .rsp_grant(rsp_grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  tag;
        logic        err;
        bit          known;
        int          acceptCycle;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic [31:0] mdlMem   [DEPTH_WORDS];
    bit          mdlKnown [DEPTH_WORDS];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          outstanding = 0;
    int          lastPopCycle = -1;
    int          acceptTotal = 0;
    bit          headTracked = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: predict on accept, compare whenever a response is presented.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            outstanding  = 0;
            cycle        = 0;
            lastPopCycle = -1;
            headTracked  = 1'b0;
        end else begin
            checkOutput("req_ready", {31'b0, req_ready}, {31'b0, (outstanding < QDEPTH)});
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rsp_unexpected: rsp_valid=1 tag=%0d, expected no response", rsp_tag);
                end else begin
                    if (!headTracked) begin
                        int expCycle;
                        expCycle = sbq[0].acceptCycle + 1 + LATENCY;
                        if (lastPopCycle + 1 > expCycle) expCycle = lastPopCycle + 1;
                        checkOutput("rsp_latency", cycle, expCycle);
                        headTracked = 1'b1;
                    end
                    if (sbq[0].known) checkOutput("rsp_data", rsp_data, sbq[0].data);
                    checkOutput("rsp_tag", {26'b0, rsp_tag}, {26'b0, sbq[0].tag});
                    checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, sbq[0].err});
                    if (rsp_grant) begin
                        void'(sbq.pop_front());
                        outstanding--;
                        headTracked  = 1'b0;
                        lastPopCycle = cycle;
                    end
                end
            end
            if (req_valid && req_ready) begin
                int  idx;
                bit  mis;
                idx = int'(req_addr[AW+1:2]);
`ifdef DMEM_ALIGN_CHK_EN
                mis = (req_addr[1:0] != 2'b00);
`else
                mis = 1'b0;
`endif
                e.tag         = req_tag;
                e.acceptCycle = cycle;
                e.known       = 1'b1;
                e.err         = mis;
                if (mis) begin
                    e.data = 32'h0;
                end else if (req_we) begin
                    mdlMem[idx]   = req_wdata;
                    mdlKnown[idx] = 1'b1;
                    e.data        = req_wdata;
                end else begin
                    e.data  = mdlMem[idx];
                    e.known = mdlKnown[idx];
                end
                sbq.push_back(e);
                outstanding++;
                acceptTotal++;
            end
            cycle++;
        end
    end

    task automatic applyStimulus(input bit v, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [5:0] tag, input bit grant);
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_tag   = tag;
        rsp_grant = grant;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit grant, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 6'd0, grant);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sbq.size() != 0; i++) idle(1'b1, 1);
        checkOutput("drain_queue_empty", sbq.size(), 0);
    endtask

    task automatic checkResetState();
        checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_data", rsp_data, 32'd0);
        checkOutput("reset_rsp_tag", {26'b0, rsp_tag}, 32'd0);
        checkOutput("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    endtask

    task automatic randomTraffic(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] addr;
            logic [31:0] low;
            low  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0;
            addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | low;
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, addr,
                          $urandom, 6'($urandom_range(0, 63)), $urandom_range(0, 9) < 6);
        end
    endtask

    initial begin
        int a0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkResetState();

        // Preload words 0..31 so random loads have known contents.
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b1, 32'(i * 4), $urandom, 6'(i), 1'b1);
        drain();

        applyStimulus(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 6'd5, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 6'd6, 1'b1);
        drain();

        applyStimulus(1'b1, 1'b1, 32'h1000, 32'h1234, 6'd7, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0000, 32'h0, 6'd8, 1'b1);
        drain();

        applyStimulus(1'b1, 1'b1, 32'h41, 32'hFF, 6'd9, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 6'd10, 1'b1);
        drain();

        a0 = acceptTotal;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'(i * 4), 32'h0, 6'(20 + i), 1'b0);
        checkOutput("bp_accepted", acceptTotal - a0, QDEPTH);
        checkOutput("bp_ready_low", {31'b0, req_ready}, 32'd0);
        idle(1'b1, 1);
        checkOutput("bp_ready_after_pop", {31'b0, req_ready}, 32'd1);
        drain();

        applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 6'd30, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'hC, 32'h0, 6'd31, 1'b0);
        idle(1'b0, 3);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 6'd32, 1'b1);
        checkOutput("sim_ready_held", {31'b0, req_ready}, 32'd1);
        checkOutput("sim_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        idle(1'b0, 1);
        checkOutput("sim_ready_after", {31'b0, req_ready}, 32'd1);
        drain();

        randomTraffic(400);

        rst_n = 1'b0;
        idle(1'b0, 2);
        rst_n = 1'b1;
        checkResetState();
        randomTraffic(200);
        drain();
        checkOutput("final_rsp_valid", {31'b0, rsp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
